// File: rtl/ser_pkg.sv
// Shared serial-link definitions used by both the deserializer and the
// parallel-to-serial transmitter: FSM state encodings, default word width
// and the parity convention.
package ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } ser_state_e;

  localparam int DEF_WIDTH = 32;

  // Even parity: XOR over data bits and parity bit is 0 on a clean frame.
  localparam logic PARITY_EVEN = 1'b0;

endpackage

// File: rtl/serial_to_parallel_if.sv
// Serial input / parallel word output bundle for serial_to_parallel.
// master: the link/consumer side (testbench); slave: the deserializer.
interface serial_to_parallel_if
  import ser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             s_valid;
  logic             s_data;
  logic             s_sync;
  logic [WIDTH-1:0] p_data;
  logic             p_valid;
  logic             p_ready;
  logic             p_perr;
  logic             overrun;
  logic             frame_err;

  modport master (
    output s_valid, s_data, s_sync, p_ready,
    input  p_data, p_valid, p_perr, overrun, frame_err
  );

  modport slave (
    input  s_valid, s_data, s_sync, p_ready,
    output p_data, p_valid, p_perr, overrun, frame_err
  );
endinterface

// File: rtl/ser_out_buf.sv
// One-entry valid/ready word holder. A completed word is taken when the
// holder is empty or being drained the same cycle; otherwise it is dropped
// and overrun pulses for one cycle while the held word stays untouched.
module ser_out_buf
  import ser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_word,
  input  logic             ld_perr,
  input  logic             p_ready,
  output logic [WIDTH-1:0] p_data,
  output logic             p_valid,
  output logic             p_perr,
  output logic             overrun
);
  logic [WIDTH-1:0] p_data_q, p_data_d;
  logic             p_valid_q, p_valid_d;
  logic             p_perr_q, p_perr_d;
  logic             overrun_q, overrun_d;

  // Load / drain / drop decision for the held word.
  always_comb begin
    p_data_d  = p_data_q;
    p_valid_d = p_valid_q;
    p_perr_d  = p_perr_q;
    overrun_d = 1'b0;
    if (ld_valid) begin
      if (!p_valid_q || p_ready) begin
        p_data_d  = ld_word;
        p_perr_d  = ld_perr;
        p_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (p_valid_q && p_ready) begin
      p_valid_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_data_q  <= '0;
      p_valid_q <= 1'b0;
      p_perr_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      p_data_q  <= p_data_d;
      p_valid_q <= p_valid_d;
      p_perr_q  <= p_perr_d;
      overrun_q <= overrun_d;
    end
  end

  assign p_data  = p_data_q;
  assign p_valid = p_valid_q;
  assign p_perr  = p_perr_q;
  assign overrun = overrun_q;
endmodule

// File: rtl/serial_to_parallel.sv
// MSB-first serial to WIDTH-bit parallel deserializer with sync-framed input,
// frame error detection and a held output word (see ser_out_buf).
// Optional feature macro: DESER_PARITY_EN (appends one even-parity bit per
// frame and reports the check result on p_perr; otherwise p_perr stays 0).
module serial_to_parallel
  import ser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic                 clk,
  input logic                 rst,
  serial_to_parallel_if.slave bus
);
  // Without parity the last data bit goes straight into the output word, so
  // the shift register only ever has to hold WIDTH-1 bits. With parity the
  // full word waits in the shift register during the parity bit.
`ifdef DESER_PARITY_EN
  localparam int SH_W = WIDTH;
`else
  localparam int SH_W = WIDTH - 1;
`endif

  ser_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SH_W-1:0]  sh_q, sh_d;
  logic             frame_err_q, frame_err_d;
  logic             ld_valid;
  logic [WIDTH-1:0] ld_word;
  logic             ld_perr;

  // Next state, bit collection and word completion. Bits enter at the LSB
  // and move up, so the sync (MSB) bit ends at WIDTH-1 after the last bit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    frame_err_d = 1'b0;
    ld_valid    = 1'b0;
    ld_word     = '0;
    ld_perr     = 1'b0;
    if (bus.s_valid) begin
      if (bus.s_sync) begin
        frame_err_d = (state_q != ST_IDLE);
        sh_d        = SH_W'(bus.s_data);
        cnt_d       = CNT_W'(1);
        state_d     = ST_SHIFT;
      end else begin
        case (state_q)
          ST_SHIFT: begin
            sh_d = (sh_q << 1) | SH_W'(bus.s_data);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              cnt_d = '0;
`ifdef DESER_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d  = ST_IDLE;
              ld_valid = 1'b1;
              ld_word  = {sh_q, bus.s_data};
`endif
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
`ifdef DESER_PARITY_EN
          ST_PARITY: begin
            state_d  = ST_IDLE;
            ld_valid = 1'b1;
            ld_word  = sh_q;
            ld_perr  = ((^sh_q) ^ bus.s_data) != PARITY_EVEN;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // FSM, bit counter, shift register and frame error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.frame_err = frame_err_q;

  ser_out_buf #(.WIDTH(WIDTH)) u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .ld_valid (ld_valid),
    .ld_word  (ld_word),
    .ld_perr  (ld_perr),
    .p_ready  (bus.p_ready),
    .p_data   (bus.p_data),
    .p_valid  (bus.p_valid),
    .p_perr   (bus.p_perr),
    .overrun  (bus.overrun)
  );
endmodule

// File: tb/tb_serial_to_parallel.sv
// Scoreboard bench for serial_to_parallel at WIDTH=8: the driver pushes
// expected words as frames are issued, a negedge monitor pops on handshake.
module tb_serial_to_parallel;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_to_parallel_if #(.WIDTH(W)) bus ();
  serial_to_parallel #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model (frame-level), expected words are {perr, data}.
  logic [W:0]   exp_q[$];
  int           exp_ov = 0, exp_fe = 0, obs_ov = 0, obs_fe = 0;
  int           m_bits = 0;
  bit           m_in_par = 0, m_held = 0;
  logic [W-1:0] m_word = '0;

  bit           hold_prev = 0;
  logic [W:0]   prev_out, mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic v, input logic sy, input logic d, input logic rdy);
    bit done;
    logic [W:0] res;
    done = 0;
    res  = '0;
    if (v) begin
      if (sy) begin
        if (m_bits > 0 || m_in_par) exp_fe++;
        m_bits   = 1;
        m_word   = W'(d);
        m_in_par = 0;
      end else if (m_in_par) begin
        res      = {(^m_word) ^ d, m_word};
        done     = 1;
        m_in_par = 0;
      end else if (m_bits > 0) begin
        m_word = {m_word[W-2:0], d};
        m_bits++;
        if (m_bits == W) begin
          m_bits = 0;
`ifdef DESER_PARITY_EN
          m_in_par = 1;
`else
          res  = {1'b0, m_word};
          done = 1;
`endif
        end
      end
    end
    if (done) begin
      if (!m_held || rdy) begin
        exp_q.push_back(res);
        m_held = 1;
      end else begin
        exp_ov++;
      end
    end else if (m_held && rdy) begin
      m_held = 0;
    end
  endtask

  task automatic cyc(input logic v, input logic sy, input logic d, input logic rdy);
    bus.s_valid = v;
    bus.s_sync  = sy;
    bus.s_data  = d;
    bus.p_ready = rdy;
    model_step(v, sy, d, rdy);
    @(posedge clk);
    #1;
  endtask

  // mode 0: never ready, 1: always, 2: random, 3: only on the final bit
  function automatic logic rdy_of(input int mode, input bit last);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'($urandom_range(0, 1));
      default: return last;
    endcase
  endfunction

  task automatic send_frame(input logic [W-1:0] w, input int gap_pct, input int rmode, input bit par_flip);
    int   nb;
    logic d;
    nb = W;
`ifdef DESER_PARITY_EN
    nb = W + 1;
`endif
    for (int i = 0; i < nb; i++) begin
      while ($urandom_range(0, 99) < gap_pct) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), rdy_of(rmode, 0));
      if (i < W) d = w[W-1-i];
      else       d = (^w) ^ par_flip;
      cyc(1'b1, i == 0, d, rdy_of(rmode, i == nb - 1));
    end
  endtask

  task automatic send_partial(input int n, input int gap_pct, input int rmode);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 99) < gap_pct) cyc(1'b0, 1'b0, 1'b0, rdy_of(rmode, 0));
      cyc(1'b1, i == 0, 1'($urandom_range(0, 1)), rdy_of(rmode, 0));
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, rdy);
  endtask

  // Monitor: pulse counting, hold stability and scoreboard pop on handshake.
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 0;
    end else begin
      if (bus.overrun)   obs_ov++;
      if (bus.frame_err) obs_fe++;
      if (hold_prev && bus.p_valid) check("hold_stable", {bus.p_perr, bus.p_data}, prev_out);
      if (bus.p_valid && bus.p_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", bus.p_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("word", {bus.p_perr, bus.p_data}, mon_e);
        end
      end
      hold_prev = bus.p_valid && !bus.p_ready;
      prev_out  = {bus.p_perr, bus.p_data};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    bus.s_valid = 1'b0;
    bus.s_sync  = 1'b0;
    bus.s_data  = 1'b0;
    bus.p_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_p_valid",   bus.p_valid,   0);
    check("rst_p_data",    bus.p_data,    0);
    check("rst_p_perr",    bus.p_perr,    0);
    check("rst_overrun",   bus.overrun,   0);
    check("rst_frame_err", bus.frame_err, 0);
    rst = 1'b0;
    idle(2, 1'b0);

    // Contiguous A5, held until ready.
    send_frame(8'hA5, 0, 0, 0);
    check("a5_valid", bus.p_valid, 1);
    check("a5_data",  bus.p_data,  8'hA5);
    idle(1, 1'b1);
    check("a5_cleared", bus.p_valid, 0);

    // 3C with random gaps.
    send_frame(8'h3C, 40, 1, 0);
    idle(2, 1'b1);
    check("3c_no_fe", obs_fe, 0);
    check("3c_no_ov", obs_ov, 0);

    // Overrun: 11 held, 22 dropped; then 22 accepted on the draining edge.
    send_frame(8'h11, 0, 0, 0);
    send_frame(8'h22, 0, 0, 0);
    idle(2, 1'b0);
    check("ov_held_data", bus.p_data, 8'h11);
    check("ov_pulse",     obs_ov,     1);
    send_frame(8'h22, 0, 3, 0);
    idle(2, 1'b0);
    check("ov_reload_valid", bus.p_valid, 1);
    check("ov_reload_data",  bus.p_data,  8'h22);
    check("ov_no_second",    obs_ov,      1);
    idle(1, 1'b1);

    // Sync on the 5th bit of a frame.
    send_partial(4, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    idle(2, 1'b0);
    check("fe_pulse", obs_fe, 1);
    check("fe_data",  bus.p_data, 8'hF0);
    idle(1, 1'b1);

`ifdef DESER_PARITY_EN
    send_frame(8'h03, 0, 0, 0);
    check("par_ok_perr", bus.p_perr, 0);
    idle(1, 1'b1);
    send_frame(8'h03, 0, 0, 1);
    check("par_bad_perr", bus.p_perr, 1);
    idle(1, 1'b1);
`endif

    // Reset mid-frame with a word held.
    send_frame(8'h77, 0, 0, 0);
    send_partial(4, 0, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_p_valid",   bus.p_valid,   0);
    check("mid_rst_p_data",    bus.p_data,    0);
    check("mid_rst_p_perr",    bus.p_perr,    0);
    check("mid_rst_overrun",   bus.overrun,   0);
    check("mid_rst_frame_err", bus.frame_err, 0);
    m_bits = 0;
    m_in_par = 0;
    m_held = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_frame(8'h5A, 0, 0, 0);
    check("post_rst_data", bus.p_data, 8'h5A);
    idle(1, 1'b1);

    // Randomized traffic.
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        send_partial($urandom_range(1, W - 1), 20, 2);
      end else begin
        send_frame(W'($urandom), $urandom_range(0, 30), 2, 1'($urandom_range(0, 1)));
        if (r == 1 && m_bits == 0 && !m_in_par) cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), rdy_of(2, 0));
      end
    end
    for (int k = 0; k < 50 && exp_q.size() > 0; k++) idle(1, 1'b1);
    idle(2, 1'b1);
    check("rand_drained",   exp_q.size(), 0);
    check("rand_overruns",  obs_ov, exp_ov);
    check("rand_frame_err", obs_fe, exp_fe);
    check("rand_final_valid", bus.p_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_to_parallel.md
# serial_to_parallel

Receive-side deserializer that reassembles a single-bit, MSB-first serial stream into WIDTH-bit parallel words. It is the counterpart of the team's parallel-to-serial transmitter (32-bit parallel in, 1-bit out). It sits between the serial link input and word-level consumers. Output is a valid/ready-held word register with overrun and framing detection.

## Interface
- WIDTH, 32, data word width in bits (≥2)
- CNT_W, $clog2(WIDTH), bit-counter width (derived; do not override)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- s_valid  input  1  s_data/s_sync valid this cycle
- s_data  input  1  serial bit, MSB first
- s_sync  input  1  qualified by s_valid; marks first (MSB) bit of a frame
- p_data  output  WIDTH  assembled word, stable while p_valid=1
- p_valid  output  1  word available
- p_ready  input  1  consumer accepts word when p_valid&&p_ready
- p_perr  output  1  parity error flag for current p_data (see Configuration)
- overrun  output  1  one-cycle pulse: completed word dropped
- frame_err  output  1  one-cycle pulse: s_sync arrived mid-frame

## Operation
- States: IDLE (await sync), SHIFT (collect bits), PARITY (only with DESER_PARITY_EN).
- IDLE: s_valid&&s_sync → shift reg bit WIDTH-1 = s_data, cnt=1, →SHIFT. s_valid without s_sync ignored.
- SHIFT: each s_valid shifts s_data in at LSB side (shift left); cnt++. On bit with cnt==WIDTH-1: word complete, cnt=0, →IDLE (or →PARITY).
- Completion: if !p_valid, or p_valid&&p_ready same cycle → load p_data, p_valid=1. Otherwise new word dropped, held word unchanged, overrun pulses.
- Handshake: p_valid&&p_ready clears p_valid next edge unless a word completes that cycle (then reload, p_valid stays 1).
- s_valid&&s_sync in SHIFT/PARITY: partial frame discarded, frame_err pulses, bit taken as new MSB, cnt=1, state SHIFT.
- s_valid=0 cycles: no state change (gaps allowed anywhere).
- Reset (any time, incl. mid-frame): state IDLE, cnt=0, shift reg 0, p_data=0, p_valid=0, p_perr=0, overrun=0, frame_err=0. Partial word lost.

## Timing
- Latency: p_valid and p_data update on the edge that samples the last data bit (parity bit if enabled); visible next cycle.
- Minimum frame period WIDTH cycles (WIDTH+1 with parity); back-to-back frames supported, sync may follow last bit immediately.
- overrun, frame_err: registered, high exactly one cycle after triggering edge.
- p_data never changes while p_valid=1 and p_ready=0.

## Configuration
- DESER_PARITY_EN defined: frame = WIDTH data bits + one even-parity bit; PARITY state consumes next s_valid bit; word loads there; p_perr = XOR(data, parity bit), registered with p_data. s_sync on parity bit → frame_err path.
- Undefined: no PARITY state, word completes on last data bit, p_perr tied 0. Port list identical both ways.

## Structure
- Shared package/header (ser_pkg): state encodings (ST_IDLE, ST_SHIFT, ST_PARITY), default WIDTH, even-parity convention constant, shared with the transmitter.
- Natural sub-module: ser_out_buf (one-entry valid/ready word holder with overrun detect); FSM, counter, shift register stay in top.

## Test plan
- WIDTH=8, no parity: sync+bits 1010_0101 contiguous → p_data=8'hA5, p_valid high cycle after 8th bit; p_ready=1 → p_valid low next cycle.
- Random s_valid gaps inside frame 8'h3C → p_data=8'h3C, no error pulses.
- p_ready=0, send 8'h11 then 8'h22 → p_data stays 8'h11, overrun one-cycle pulse at 8'h22 completion; then p_ready=1 with completion same cycle → 8'h22 accepted without overrun.
- s_sync on 5th bit of a frame, then full 8'hF0 → frame_err pulse, p_data=8'hF0.
- DESER_PARITY_EN: 8'h03 + parity 0 → p_perr=0; 8'h03 + parity 1 → p_perr=1.
- rst asserted mid-frame (after 4 bits) → all outputs 0 immediately; next full frame 8'h5A received correctly.
